// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Decode-stage register file with a per-register pending-write scoreboard.
//   NRD combinational read ports with write-through bypass from the writeback
//   port. Register NREG-1 is the PC slot: reads return pc_plus8 and writes
//   to it are discarded. Each architectural register r < NREG-1 carries a
//   pending-write counter, so that Decode stalls while a source operand still
//   has a write in flight.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   ra_flat / rd_flat       packed read addresses / read data, port i at slice i
//   pc_plus8                value returned for reads of NREG-1
//   we3, wa3, wd3           writeback port
//   wb_release              writeback instruction frees its reservation on wa3
//   issue_valid, issue_we,
//   issue_dst               Decode issue request and its destination register
//   flush                   clears all reservations (register contents are kept)
//   stall, issue_ack        combinational hazard / issue-accept outputs
//   sb_err                  sticky flag: release with no outstanding reservation
module regfile_scoreboard #(
    parameter int WIDTH   = 32,
    parameter int NREG    = 16,
    parameter int ABITS   = 4,
    parameter int NRD     = 3,
    parameter int MAXPEND = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRD*ABITS-1:0]   ra_flat,
    output logic [NRD*WIDTH-1:0]   rd_flat,
    input  logic [WIDTH-1:0]       pc_plus8,
    input  logic                   we3,
    input  logic [ABITS-1:0]       wa3,
    input  logic [WIDTH-1:0]       wd3,
    input  logic                   wb_release,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic [ABITS-1:0]       issue_dst,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue_ack,
    output logic                   sb_err
);

    localparam int              PW     = $clog2(MAXPEND + 1);
    localparam int              NARCH  = NREG - 1;
    localparam logic [ABITS-1:0] PC_IDX = ABITS'(NREG - 1);
    localparam logic [PW-1:0]   PMAX   = PW'(MAXPEND);

    logic [WIDTH-1:0] regs_q [NARCH];
    logic [PW-1:0]    pend_q [NARCH];
    logic [PW-1:0]    pend_d [NARCH];
    logic             sb_err_q, sb_err_d;

    logic wa_ok, dst_ok, dec, inc;

    assign wa_ok  = (wa3 < PC_IDX);
    assign dst_ok = (issue_dst < PC_IDX);
    assign dec    = wb_release && wa_ok;
    assign inc    = issue_ack && issue_we && dst_ok;

    assign issue_ack = issue_valid && !stall;
    assign sb_err    = sb_err_q;

    // Read ports and stall. Array lookups are done by compare-and-select over
    // the architectural registers so PC-slot and out-of-range addresses fall
    // through to a zero default without ever indexing past the array.
    always_comb begin : read_stall
        logic [ABITS-1:0] ra_v;
        logic [WIDTH-1:0] rdata_v;
        logic [PW-1:0]    pnd_v;
        logic [PW-1:0]    dst_pnd_v;

        rd_flat   = '0;
        stall     = 1'b0;
        dst_pnd_v = '0;

        for (int i = 0; i < NRD; i++) begin
            ra_v    = ra_flat[i*ABITS +: ABITS];
            rdata_v = '0;
            pnd_v   = '0;
            for (int r = 0; r < NARCH; r++) begin
                if (ra_v == ABITS'(r)) begin
                    rdata_v = regs_q[r];
                    pnd_v   = pend_q[r];
                end
            end
            if (ra_v == PC_IDX)
                rdata_v = pc_plus8;
            else if (we3 && wa_ok && (wa3 == ra_v))
                rdata_v = wd3;
            rd_flat[i*WIDTH +: WIDTH] = rdata_v;

            // A release in this same cycle is forwarded through the bypass.
            if ((pnd_v != '0) && !(dec && (wa3 == ra_v)))
                stall = 1'b1;
        end

        for (int r = 0; r < NARCH; r++) begin
            if (issue_dst == ABITS'(r))
                dst_pnd_v = pend_q[r];
        end

        // Overflow guard. A coincident release on the same register frees a
        // slot, so the issue may proceed and the counter holds at MAXPEND.
        if (issue_valid && issue_we && dst_ok && (dst_pnd_v == PMAX)
            && !(dec && (wa3 == issue_dst)))
            stall = 1'b1;
    end

    always_comb begin : pend_next
        logic hit_inc, hit_dec;

        sb_err_d = sb_err_q;
        for (int r = 0; r < NARCH; r++) begin
            hit_inc   = inc && (issue_dst == ABITS'(r));
            hit_dec   = dec && (wa3 == ABITS'(r));
            pend_d[r] = pend_q[r];
            if (hit_inc && !hit_dec)
                pend_d[r] = pend_q[r] + PW'(1);
            else if (hit_dec && !hit_inc) begin
                if (pend_q[r] == '0)
                    sb_err_d = 1'b1;
                else
                    pend_d[r] = pend_q[r] - PW'(1);
            end
            if (flush)
                pend_d[r] = '0;
        end
        // A release racing a flush has nothing left to release.
        if (flush)
            sb_err_d = sb_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NARCH; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NARCH; r++) begin
                if (we3 && (wa3 == ABITS'(r)))
                    regs_q[r] <= wd3;
                pend_q[r] <= pend_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int WIDTH = 32;
    localparam int ABITS = 4;
    localparam int NRD   = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*ABITS-1:0] ra_flat;
    logic [NRD*WIDTH-1:0] rd_flat;
    logic [WIDTH-1:0]     pc_plus8;
    logic                 we3;
    logic [ABITS-1:0]     wa3;
    logic [WIDTH-1:0]     wd3;
    logic                 wb_release;
    logic                 issue_valid;
    logic                 issue_we;
    logic [ABITS-1:0]     issue_dst;
    logic                 flush;
    logic                 stall;
    logic                 issue_ack;
    logic                 sb_err;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .ra_flat     (ra_flat),
        .rd_flat     (rd_flat),
        .pc_plus8    (pc_plus8),
        .we3         (we3),
        .wa3         (wa3),
        .wd3         (wd3),
        .wb_release  (wb_release),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_dst   (issue_dst),
        .flush       (flush),
        .stall       (stall),
        .issue_ack   (issue_ack),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    // kind: 0..2 = rd port, 3 = stall, 4 = issue_ack, 5 = sb_err
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: the driver pushes expectations right after a rising edge; the
    // monitor drains them on the falling edge of the same cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0, 1, 2: act = rd_flat[e.kind*WIDTH +: WIDTH];
                3:       act = {31'd0, stall};
                4:       act = {31'd0, issue_ack};
                default: act = {31'd0, sb_err};
            endcase
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, act, e.val);
            end
        end
    end

    task automatic exp_rd(input string tag, input int port, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = port; e.val = v;
        q.push_back(e);
    endtask

    task automatic exp_fl(input string tag, input logic s, input logic a, input logic er);
        exp_t e;
        e.tag = {tag, ".stall"};  e.kind = 3; e.val = {31'd0, s};  q.push_back(e);
        e.tag = {tag, ".ack"};    e.kind = 4; e.val = {31'd0, a};  q.push_back(e);
        e.tag = {tag, ".sb_err"}; e.kind = 5; e.val = {31'd0, er}; q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset       = 1'b0;
        we3         = 1'b0;
        wa3         = '0;
        wd3         = '0;
        wb_release  = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dst   = '0;
        flush       = 1'b0;
        ra_flat     = '0;
    endtask

    task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        ra_flat = {a2, a1, a0};
    endtask

    task automatic issue(input logic [3:0] dst);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_dst   = dst;
    endtask

    task automatic release_wb(input logic [3:0] a, input logic w, input logic [31:0] d);
        wb_release = 1'b1;
        wa3        = a;
        we3        = w;
        wd3        = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        pc_plus8 = 32'h10;
        reset    = 1'b1;
        tick();
        tick();

        // Reset state
        idle(); set_ra(0, 5, 15);
        exp_rd("rst.rd0", 0, 32'h0);
        exp_rd("rst.rd1", 1, 32'h0);
        exp_rd("rst.rd2", 2, 32'h10);
        exp_fl("rst", 1'b0, 1'b0, 1'b0);
        tick();

        // Write-through bypass, then stored value
        idle(); set_ra(2, 15, 2); we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hDEADBEEF;
        exp_rd("byp.rd0", 0, 32'hDEADBEEF);
        exp_rd("byp.rd1", 1, 32'h10);
        exp_rd("byp.rd2", 2, 32'hDEADBEEF);
        tick();
        idle(); set_ra(2, 0, 0);
        exp_rd("wr.rd0", 0, 32'hDEADBEEF);
        exp_rd("wr.rd1", 1, 32'h0);
        tick();

        // Reservation on r1, RAW stall, release resolves via bypass
        idle(); issue(4'd1);
        exp_fl("iss1", 1'b0, 1'b1, 1'b0);
        tick();
        idle(); issue(4'd6); set_ra(0, 1, 0);
        exp_fl("raw1", 1'b1, 1'b0, 1'b0);
        tick();
        idle(); set_ra(0, 1, 0); release_wb(4'd1, 1'b1, 32'd7);
        exp_rd("rel1.rd1", 1, 32'd7);
        exp_fl("rel1", 1'b0, 1'b0, 1'b0);
        tick();
        idle(); set_ra(0, 1, 0);
        exp_rd("post1.rd1", 1, 32'd7);
        exp_fl("post1", 1'b0, 1'b0, 1'b0);
        tick();

        // Fill r3 to MAXPEND, overflow guard, simultaneous issue+release
        for (int k = 0; k < 3; k++) begin
            idle(); issue(4'd3);
            exp_fl($sformatf("fill3_%0d", k), 1'b0, 1'b1, 1'b0);
            tick();
        end
        idle(); issue(4'd3);
        exp_fl("ovf3", 1'b1, 1'b0, 1'b0);
        tick();
        idle(); issue(4'd3); release_wb(4'd3, 1'b1, 32'h33);
        exp_fl("swap3", 1'b0, 1'b1, 1'b0);
        tick();
        idle(); issue(4'd3);
        exp_fl("ovf3b", 1'b1, 1'b0, 1'b0);
        tick();

        // Drain r3: three releases needed
        for (int k = 0; k < 2; k++) begin
            idle(); release_wb(4'd3, 1'b0, 32'h0);
            exp_fl($sformatf("drain3_%0d", k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(); set_ra(3, 0, 0);
        exp_rd("r3.rd0", 0, 32'h33);
        exp_fl("pend3_1", 1'b1, 1'b0, 1'b0);
        tick();
        idle(); set_ra(3, 0, 0); release_wb(4'd3, 1'b0, 32'h0);
        exp_fl("drain3_2", 1'b0, 1'b0, 1'b0);
        tick();
        idle(); set_ra(3, 0, 0);
        exp_fl("pend3_0", 1'b0, 1'b0, 1'b0);
        tick();

        // Flush with pend[4]=2; data kept; later release flags error
        idle(); issue(4'd4); we3 = 1'b1; wa3 = 4'd4; wd3 = 32'h0000A5A5;
        exp_fl("iss4a", 1'b0, 1'b1, 1'b0);
        tick();
        idle(); issue(4'd4);
        exp_fl("iss4b", 1'b0, 1'b1, 1'b0);
        tick();
        idle(); set_ra(4, 0, 0);
        exp_fl("pend4", 1'b1, 1'b0, 1'b0);
        tick();
        idle(); flush = 1'b1; issue(4'd5);
        exp_fl("flush", 1'b0, 1'b1, 1'b0);
        tick();
        idle(); set_ra(4, 5, 0);
        exp_rd("flush.rd0", 0, 32'h0000A5A5);
        exp_fl("postflush", 1'b0, 1'b0, 1'b0);
        tick();
        idle(); release_wb(4'd4, 1'b0, 32'h0);
        exp_fl("badrel", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        exp_fl("errset", 1'b0, 1'b0, 1'b1);
        tick();
        idle(); reset = 1'b1;
        tick();
        idle(); set_ra(4, 2, 15);
        exp_rd("rst2.rd0", 0, 32'h0);
        exp_rd("rst2.rd1", 1, 32'h0);
        exp_rd("rst2.rd2", 2, 32'h10);
        exp_fl("rst2", 1'b0, 1'b0, 1'b0);
        tick();

        // Write to R15 is discarded; r0..r14 stay zero
        idle(); set_ra(15, 0, 0); we3 = 1'b1; wa3 = 4'd15; wd3 = 32'h55;
        exp_rd("w15.rd0", 0, 32'h10);
        exp_rd("w15.rd1", 1, 32'h0);
        exp_fl("w15", 1'b0, 1'b0, 1'b0);
        tick();
        pc_plus8 = 32'h1234;
        for (int b = 0; b < 15; b += 3) begin
            idle(); set_ra(4'(b), 4'(b + 1), 4'(b + 2));
            exp_rd($sformatf("r%0d", b),     0, 32'h0);
            exp_rd($sformatf("r%0d", b + 1), 1, 32'h0);
            exp_rd($sformatf("r%0d", b + 2), 2, 32'h0);
            tick();
        end
        idle(); set_ra(15, 15, 15);
        exp_rd("pc.rd0", 0, 32'h1234);
        exp_rd("pc.rd2", 2, 32'h1234);
        tick();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
